// File: rtl/mat_mult_pkg.sv
// mat_mult_pkg: sequencer states, word geometry and byte-lane extract/pack helpers
package mat_mult_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, STORE, DONE} state_t;
  localparam int ELEMS_PER_WORD = 4;
  localparam int WORD_WIDTH = 32;
  function automatic logic [7:0] get_byte(input logic [WORD_WIDTH-1:0] w, input logic [1:0] l);
    return w[8*l +: 8];
  endfunction
  function automatic logic [WORD_WIDTH-1:0] put_byte(input logic [WORD_WIDTH-1:0] w, input logic [1:0] l, input logic [7:0] b);
    logic [WORD_WIDTH-1:0] r;
    r = w;
    r[8*l +: 8] = b;
    return r;
  endfunction
endpackage

// File: rtl/mat_mult_ctrl_if.sv
// mat_mult_ctrl_if: word memory port; master drives req/we/addr/wdata, slave returns gnt/rvalid/rdata
interface mat_mult_ctrl_if
  import mat_mult_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
);
  logic req, we, gnt, rvalid;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0] wdata, rdata;
  modport master(output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mat_mac.sv
// mat_mac: wrapping multiply-accumulate; ports clk, rst_n, clr_i, en_i, a_i, b_i in, sum_o out (value the accumulator takes this cycle)
module mat_mac #(
  parameter int DAT_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic [DAT_SIZE-1:0] a_i,
  input  logic [DAT_SIZE-1:0] b_i,
  output logic [DAT_SIZE-1:0] sum_o
);
  logic [DAT_SIZE-1:0] acc, prod;
  assign prod = a_i * b_i;
  assign sum_o = (clr_i ? '0 : acc) + prod;
  always_ff @(posedge clk)
    if (!rst_n) acc <= '0;
    else if (en_i) acc <= sum_o;
endmodule

// File: rtl/mat_mult_ctrl.sv
// mat_mult_ctrl: fetch A/B over mem, compute C=AxB with one MAC, write packed C back; ports clk, rst_n, start_i, a/b/c_addr_i in, busy_o, done_o out, mem master
module mat_mult_ctrl
  import mat_mult_pkg::*;
#(
  parameter int MAT_SIZE = 4,
  parameter int DAT_SIZE = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [ADDR_WIDTH-1:0] c_addr_i,
  output logic busy_o,
  output logic done_o,
  mat_mult_ctrl_if.master mem
);
  localparam int N = MAT_SIZE;
  localparam int W = N * N / ELEMS_PER_WORD;
  localparam int CW = $clog2(W);
  localparam int IW = $clog2(N);
  localparam int BW = CW + 2;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] b_base, c_base, addr_nxt;
  logic [CW-1:0] wcnt, wcnt_nxt;
  logic [IW-1:0] i, j, k;
  logic [BW-1:0] ai, bi;
  logic [DAT_SIZE-1:0] a_buf [N*N];
  logic [DAT_SIZE-1:0] b_buf [N*N];
  logic [DAT_SIZE-1:0] sum;
  logic req_nxt, we_nxt, loading, rd_done, comp, last_word, last_k, last_j;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign loading = state == LOAD_A || state == LOAD_B;
  assign rd_done = loading && !mem.req && mem.rvalid;
  assign comp = state == COMPUTE;
  assign last_word = wcnt == CW'(W - 1);
  assign last_k = k == IW'(N - 1);
  assign last_j = j == IW'(N - 1);
  assign ai = BW'(i) * BW'(N) + BW'(k);
  assign bi = BW'(k) * BW'(N) + BW'(j);
  mat_mac #(.DAT_SIZE(DAT_SIZE)) u_mac (
    .clk(clk),
    .rst_n(rst_n),
    .clr_i(k == '0),
    .en_i(comp),
    .a_i(a_buf[ai]),
    .b_i(b_buf[bi]),
    .sum_o(sum)
  );
  always_comb begin
    state_nxt = state;
    req_nxt = mem.req;
    we_nxt = mem.we;
    addr_nxt = mem.addr;
    wcnt_nxt = wcnt;
    case (state)
      IDLE: if (start_i) begin
        state_nxt = LOAD_A;
        req_nxt = 1'b1;
        we_nxt = 1'b0;
        addr_nxt = a_addr_i;
        wcnt_nxt = '0;
      end
      LOAD_A, LOAD_B:
        if (mem.req && mem.gnt) req_nxt = 1'b0;
        else if (rd_done) begin
          wcnt_nxt = last_word ? '0 : wcnt + CW'(1);
          req_nxt = !(last_word && state == LOAD_B);
          addr_nxt = last_word ? b_base : mem.addr + ADDR_WIDTH'(1);
          state_nxt = !last_word ? state : state == LOAD_A ? LOAD_B : COMPUTE;
        end
      COMPUTE: if (last_k && j[1:0] == 2'd3) begin
        state_nxt = STORE;
        req_nxt = 1'b1;
        we_nxt = 1'b1;
        addr_nxt = c_base + ADDR_WIDTH'(wcnt);
      end
      STORE: if (mem.gnt) begin
        state_nxt = last_word ? DONE : COMPUTE;
        req_nxt = 1'b0;
        we_nxt = 1'b0;
        wcnt_nxt = last_word ? '0 : wcnt + CW'(1);
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nxt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      mem.req <= 1'b0;
      mem.we <= 1'b0;
      mem.addr <= '0;
      mem.wdata <= '0;
      wcnt <= '0;
      i <= '0;
      j <= '0;
      k <= '0;
      b_base <= '0;
      c_base <= '0;
    end else begin
      mem.req <= req_nxt;
      mem.we <= we_nxt;
      mem.addr <= addr_nxt;
      wcnt <= wcnt_nxt;
      if (state == IDLE && start_i) begin
        b_base <= b_addr_i;
        c_base <= c_addr_i;
        i <= '0;
        j <= '0;
        k <= '0;
      end
      if (comp) begin
        k <= last_k ? '0 : k + IW'(1);
        if (last_k) begin
          mem.wdata <= put_byte(mem.wdata, j[1:0], sum);
          j <= last_j ? '0 : j + IW'(1);
          if (last_j) i <= i + IW'(1);
        end
      end
    end
  always_ff @(posedge clk)
    if (rd_done)
      for (int b = 0; b < ELEMS_PER_WORD; b++)
        if (state == LOAD_A) a_buf[{wcnt, 2'(b)}] <= get_byte(mem.rdata, 2'(b));
        else b_buf[{wcnt, 2'(b)}] <= get_byte(mem.rdata, 2'(b));
endmodule

// File: doc/mat_mult_ctrl.md
# mat_mult_ctrl

Sequencer for the 8-bit matrix-multiply accelerator. On a start pulse it:
- fetches the packed A and B matrices over a PULPino-style word memory port into local buffers;
- runs C = A×B through a single multiply-accumulate unit, one MAC per cycle;
- packs the results four bytes per word and writes them back to memory;
- raises a one-cycle done pulse when finished.

It sits between the peripheral/config registers (which supply base addresses and start) and data memory.

## Interface
Parameters:
- MAT_SIZE, 4: matrix dimension N. Must be a multiple of 4, range 4..16.
- DAT_SIZE, 8: element width in bits. Fixed at 8; other values are not supported.
- ADDR_WIDTH, 8: word-address width of the memory port.

Ports:
- clk  in  1  clock. The block uses one clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- start_i  in  1  start request. Sampled only in IDLE.
- a_addr_i  in  ADDR_WIDTH  base word address of A. Sampled with start_i.
- b_addr_i  in  ADDR_WIDTH  base word address of B. Sampled with start_i.
- c_addr_i  in  ADDR_WIDTH  base word address of C. Sampled with start_i.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  ADDR_WIDTH  word address.
- mem_wdata_o  out  32  packed C word.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  read data valid. Ignored for writes.
- mem_rdata_i  in  32  read data.

## Operation
- Matrix layout:
  - Row-major, 4 elements per word. Element (r,c) lives in word base + (r·N+c)/4, bits [8·((r·N+c)%4)+7 : 8·((r·N+c)%4)].
  - W = N²/4 words per matrix.
- States: IDLE → LOAD_A → LOAD_B → COMPUTE ⇄ STORE → DONE → IDLE.
- IDLE:
  - On start_i=1, latch the three base addresses, clear word counters, go to LOAD_A.
  - start_i in any other state is ignored.
- LOAD_A / LOAD_B:
  - One outstanding read at a time: assert req with we=0 and hold addr stable until gnt.
  - After gnt, deassert req and wait for rvalid, then store the 4 bytes in the local buffer.
  - After W words, advance to the next state.
- COMPUTE:
  - Produces one C word: 4 consecutive elements, each the sum over k=0..N-1 of A[i][k]·B[k][j], one MAC per cycle, so 4N cycles per word.
  - Accumulator clears at k=0.
  - Arithmetic is modulo 2^8: the product is truncated to 8 bits and the accumulator wraps.
- STORE:
  - Assert req with we=1, addr = c_base + word index, wdata = the packed word. Hold until gnt.
  - After gnt: go to COMPUTE if words remain, else DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- In-place operation is legal. A and B are fully buffered before any write, so c_addr_i may equal a_addr_i or b_addr_i.
- Reset mid-operation:
  - Next edge returns to IDLE.
  - All outputs return to reset values; no further writes are issued.
  - A late rvalid arriving after reset is ignored.

## Timing
- Reset values: busy_o=0, done_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are registered. They remain stable from req rise until the gnt cycle inclusive.
- Zero-wait memory (gnt in the req cycle, rvalid the next cycle):
  - 2 cycles per read word, 1 cycle per write word.
  - start sampled at cycle 0; done_o is high in cycle 1 + 4W + W·(4N+1).
  - For N=4 that is cycle 85.
- busy_o rises in cycle 1 and falls in the cycle after done_o.
- A start_i arriving in the done_o cycle is ignored.
- A start_i arriving in the following IDLE cycle is accepted.
- Wait states stretch only the LOAD and STORE phases; compute cycles are unaffected.

## Structure
- Package mat_mult_pkg contains:
  - state enum state_t (IDLE, LOAD_A, LOAD_B, COMPUTE, STORE, DONE);
  - ELEMS_PER_WORD=4;
  - WORD_WIDTH=32;
  - byte-lane extract/pack functions.
- Sub-module mat_mac: 8-bit multiply-accumulate with clr_i and en_i, registered accumulator. The controller instantiates one.
- A/B buffers are flop arrays of N² bytes each inside mat_mult_ctrl.

## Test plan
- Identity: N=4, A=I, B=0x01..0x10 row-major, zero-wait memory. C must equal B word-for-word, done_o in cycle 85, exactly 4 writes at c_addr..c_addr+3.
- Wrap: A and B all 0xFF. Every C byte = 4·0x01 = 0x04, i.e. each word 0x04040404.
- Wait states: random gnt delay 0–3 cycles and rvalid delay 1–2 cycles. Results must match the identity and wrap cases, and addr/we/wdata must never change while req=1 and gnt=0.
- Start while busy: pulse start_i in LOAD_B and again in the done_o cycle. There must be only one done_o and no second fetch; a start 1 cycle later must run normally.
- Reset mid-COMPUTE: assert rst_n=0 for 1 cycle. All outputs go to reset values next cycle and no write occurs; a restart then produces correct C.
- In-place: c_addr_i = a_addr_i. C must be correct and A's region must contain C afterwards.
